sprite_plot_scheduler: RTL and testbench
========================================

// Module: sprite_plot_scheduler
// PURPOSE
// - Single owner of the one vga_adapter pixel-write port (x, y, colour, plot); bird and hunter sprites never drive it directly.
// - On each frame tick it services every requesting sprite in turn.
// - Per sprite: erase the old 13-pixel duck footprint with background, then draw the new footprint at the latched position.
// - Sits between the frame_counter / sprite movers and vga_adapter.
// PARAMETERS
// - NUM_SPR    2       number of sprite requesters (index 0 = highest priority)
// - PIX_N      13      pixels per sprite footprint
// - SCR_W      160     screen width; x >= SCR_W is clipped
// - SCR_H      120     screen height; y >= SCR_H is clipped
// - BG_COLOUR  3'b000  erase colour
// PORTS
// - clock       in   1          system clock (CLOCK_50 domain)
// - resetn      in   1          synchronous, active-low reset
// - frame_tick  in   1          1-cycle pulse, start of frame pass
// - req         in   NUM_SPR    sprite i wants servicing this frame
// - visible     in   NUM_SPR    1 = erase+draw, 0 = erase only (e.g. bird shot)
// - spr_x       in   8*NUM_SPR  sprite i origin x, slice [8i+7:8i]
// - spr_y       in   7*NUM_SPR  sprite i origin y, slice [7i+6:7i]
// - spr_colour  in   3*NUM_SPR  sprite i draw colour
// - ack         out  NUM_SPR    1-cycle pulse, sprite i finished
// - vga_x       out  8          to vga_adapter.x
// - vga_y       out  7          to vga_adapter.y
// - vga_colour  out  3          to vga_adapter.colour
// - vga_plot    out  1          to vga_adapter.plot
// - busy        out  1          frame pass in progress
// - overrun     out  1          1-cycle pulse, frame_tick arrived while busy
// BEHAVIOUR
// - Reset (resetn=0 at posedge), effective next cycle:
//   - state=IDLE; pending=0; all prev_valid=0.
//   - All outputs 0.
//   - Reset mid-pass aborts immediately; no ack is issued.
// - FSM states: IDLE, ARB, ERASE, DRAW, ACK.
// - IDLE:
//   - On frame_tick: pending<=req; go ARB if req!=0, else stay.
//   - No snapshot is taken when req=0.
// - ARB (1 cycle): select the lowest set index s in pending; latch into working regs:
//   - spr_x[s], spr_y[s], spr_colour[s], visible[s];
//   - prev_x[s], prev_y[s], prev_valid[s].
//   - Next state: ERASE if prev_valid[s], else DRAW if visible[s], else ACK.
// - ERASE: pixel index k=0..PIX_N-1, one pixel per cycle, at prev + offset[k], colour BG_COLOUR.
//   - Next: DRAW if visible, else ACK.
// - DRAW: k=0..PIX_N-1 at latched origin + offset[k], colour = latched colour.
// - ACK (1 cycle):
//   - ack[s]=1; clear pending[s].
//   - prev_x/y[s] <= latched origin; prev_valid[s] <= visible latch.
//   - Go ARB if pending is still nonzero, else IDLE.
// - Footprint offsets (dx,dy), k=0..12:
//   - (0,0) (0,+1) (-1,0) (-2,0) (-3,0) (-4,0) (-5,0)
//   - (-3,+1) (-3,-1) (-4,+2) (-4,-2) (-5,+3) (-5,-3)
// - Arithmetic and clipping:
//   - Compute x in 9-bit signed and y in 8-bit signed.
//   - Result <0, x>=SCR_W or y>=SCR_H: vga_plot=0 that cycle; k still advances, so timing is fixed.
// - Output timing:
//   - vga_* are registered: pixel k appears the cycle after the FSM is at index k.
//   - vga_plot=0 in IDLE, ARB and ACK.
// - Latency per sprite (ARB to ACK inclusive):
//   - 28 cycles with erase+draw.
//   - 15 cycles draw-only or erase-only.
//   - 2 cycles with neither.
// - Inputs:
//   - Inputs are sampled only in ARB, so changes during ERASE/DRAW do not tear.
//   - req is sampled only at frame_tick.
// - busy = (state != IDLE).
// - frame_tick while busy: ignored, overrun pulses; no new snapshot is taken.
// STRUCTURE
// - Package duck_pkg holds:
//   - FSM state localparams;
//   - coordinate widths (X_W=8, Y_W=7) and BG_COLOUR;
//   - the 13-entry offset table.
// - Sub-module sprite_offset_rom: combinational, k[3:0] -> dx[3:0] and dy[3:0] signed; k>12 returns (0,0).
// - Top level holds: FSM, pixel counter, pending vector, per-sprite prev regs, clip logic, output regs.
// TESTING
// - Reset, then tick with req=2'b01, visible=1, x=50, y=60, colour=3'b111 -> 13 plots at (50,60),(50,61),(49,60)..(45,57); ack[0] after 15 cycles; no erase.
// - Second tick, sprite 0 at x=51 -> 13 plots of 000 at the old footprint, then 13 plots of 111 at the new one; ack at cycle 28.
// - req=2'b11 -> sprite 0 is fully serviced before sprite 1; ack[0] precedes ack[1]; busy stays high throughout the pass.
// - x=2, y=118 -> offsets giving x<0 or y>=120 have vga_plot=0; pass length unchanged.
// - visible=0 on a drawn sprite -> erase only, ack, then prev_valid=0: the next tick with visible=0 gives ack after 2 cycles and no plots.
// - frame_tick mid-pass -> overrun=1 for 1 cycle, pass unaffected.
// - resetn=0 mid-DRAW -> next cycle vga_plot=0 and busy=0; no ack.

Source files
------------

// File: rtl/duck_pkg.sv
// Shared types and constants for the sprite plot scheduler:
// FSM encoding, coordinate widths, erase colour and the duck footprint.
package duck_pkg;

   localparam int X_W   = 8;
   localparam int Y_W   = 7;
   localparam int TAB_N = 13;

   localparam logic [2:0] BG_COLOUR = 3'b000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARB,
      S_ERASE,
      S_DRAW,
      S_ACK
   } state_t;

   localparam logic signed [3:0] OFF_DX [TAB_N] = '{
      4'sd0, 4'sd0, -4'sd1, -4'sd2, -4'sd3, -4'sd4, -4'sd5,
      -4'sd3, -4'sd3, -4'sd4, -4'sd4, -4'sd5, -4'sd5
   };

   localparam logic signed [3:0] OFF_DY [TAB_N] = '{
      4'sd0, 4'sd1, 4'sd0, 4'sd0, 4'sd0, 4'sd0, 4'sd0,
      4'sd1, -4'sd1, 4'sd2, -4'sd2, 4'sd3, -4'sd3
   };

endpackage

// File: rtl/sprite_plot_scheduler_if.sv
// Pixel-write bus towards vga_adapter.
// The scheduler is the only master; the adapter is the slave.
interface sprite_plot_scheduler_if;
   import duck_pkg::*;

   logic [X_W-1:0] x;
   logic [Y_W-1:0] y;
   logic [2:0]     colour;
   logic           plot;

   modport master (output x, y, colour, plot);
   modport slave  (input  x, y, colour, plot);

endinterface

// File: rtl/sprite_offset_rom.sv
// Duck footprint lookup: pixel index to signed (dx, dy).
// Indices beyond the table return the origin.
module sprite_offset_rom
   import duck_pkg::*;
(
   input  logic        [3:0] k,
   output logic signed [3:0] dx,
   output logic signed [3:0] dy
);

   always_comb begin
      dx = '0;
      dy = '0;
      if (k < 4'(TAB_N)) begin
         dx = OFF_DX[k];
         dy = OFF_DY[k];
      end
   end

endmodule

// File: rtl/sprite_plot_scheduler.sv
// Owns the vga_adapter write port: per frame, erases and redraws
// each requesting sprite in priority order, one pixel per cycle.
module sprite_plot_scheduler #(
   parameter int         NUM_SPR   = 2,
   parameter int         PIX_N     = 13,
   parameter int         SCR_W     = 160,
   parameter int         SCR_H     = 120,
   parameter logic [2:0] BG_COLOUR = duck_pkg::BG_COLOUR
) (
   input  logic                            clock,
   input  logic                            resetn,
   input  logic                            frame_tick,
   input  logic [NUM_SPR-1:0]              req,
   input  logic [NUM_SPR-1:0]              visible,
   input  logic [duck_pkg::X_W*NUM_SPR-1:0] spr_x,
   input  logic [duck_pkg::Y_W*NUM_SPR-1:0] spr_y,
   input  logic [3*NUM_SPR-1:0]            spr_colour,
   output logic [NUM_SPR-1:0]              ack,
   output logic                            busy,
   output logic                            overrun,
   sprite_plot_scheduler_if.master         vga
);
   import duck_pkg::*;

   localparam int SEL_W = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
   localparam logic [3:0]   LAST_K = 4'(PIX_N - 1);
   localparam logic [X_W:0] X_LIM  = (X_W+1)'(SCR_W);
   localparam logic [Y_W:0] Y_LIM  = (Y_W+1)'(SCR_H);

   state_t state, state_d;

   logic [3:0]         k;
   logic [NUM_SPR-1:0] pending;
   logic [NUM_SPR-1:0] prev_valid;
   logic [X_W-1:0]     prev_x [NUM_SPR];
   logic [Y_W-1:0]     prev_y [NUM_SPR];
   logic [SEL_W-1:0]   pick;
   logic [SEL_W-1:0]   sel;
   logic [NUM_SPR-1:0] sel_oh;

   logic [X_W-1:0] cur_x, old_x, base_x;
   logic [Y_W-1:0] cur_y, old_y, base_y;
   logic [2:0]     cur_col;
   logic           cur_vis;

   logic               pix_on;
   logic signed [3:0]  dx, dy;
   logic [X_W:0]       px;
   logic [Y_W:0]       py;
   logic               on_screen;

   sprite_offset_rom u_rom (
      .k  (k),
      .dx (dx),
      .dy (dy)
   );

   // Last write wins, so the lowest pending index is chosen.
   always_comb begin
      pick = '0;
      for (int i = NUM_SPR - 1; i >= 0; i--) begin
         if (pending[i]) pick = SEL_W'(i);
      end
   end

   always_comb begin
      sel_oh = '0;
      sel_oh[sel] = 1'b1;
   end

   assign ack  = (state == S_ACK) ? sel_oh : '0;
   assign busy = (state != S_IDLE);

   always_ff @(posedge clock) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_d;
   end

   always_comb begin
      state_d = state;
      unique case (state)
         S_IDLE: begin
            if (frame_tick && (req != '0)) state_d = S_ARB;
         end
         S_ARB: begin
            if (prev_valid[pick])   state_d = S_ERASE;
            else if (visible[pick]) state_d = S_DRAW;
            else                    state_d = S_ACK;
         end
         S_ERASE: begin
            if (k == LAST_K) state_d = cur_vis ? S_DRAW : S_ACK;
         end
         S_DRAW: begin
            if (k == LAST_K) state_d = S_ACK;
         end
         S_ACK: begin
            if ((pending & ~sel_oh) != '0) state_d = S_ARB;
            else                           state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         pending    <= '0;
         prev_valid <= '0;
         k          <= '0;
         sel        <= '0;
         cur_x      <= '0;
         cur_y      <= '0;
         cur_col    <= '0;
         cur_vis    <= 1'b0;
         old_x      <= '0;
         old_y      <= '0;
         overrun    <= 1'b0;
      end else begin
         overrun <= frame_tick && (state != S_IDLE);
         unique case (state)
            S_IDLE: begin
               if (frame_tick && (req != '0)) pending <= req;
            end
            S_ARB: begin
               sel     <= pick;
               cur_x   <= spr_x[pick*X_W +: X_W];
               cur_y   <= spr_y[pick*Y_W +: Y_W];
               cur_col <= spr_colour[pick*3 +: 3];
               cur_vis <= visible[pick];
               old_x   <= prev_x[pick];
               old_y   <= prev_y[pick];
               k       <= '0;
            end
            S_ERASE, S_DRAW: begin
               k <= (k == LAST_K) ? 4'd0 : k + 4'd1;
            end
            S_ACK: begin
               pending[sel]    <= 1'b0;
               prev_x[sel]     <= cur_x;
               prev_y[sel]     <= cur_y;
               prev_valid[sel] <= cur_vis;
            end
            default: ;
         endcase
      end
   end

   // Sign-extended offsets; bit X_W / Y_W set means off the left/top edge.
   assign pix_on = (state == S_ERASE) || (state == S_DRAW);
   assign base_x = (state == S_ERASE) ? old_x : cur_x;
   assign base_y = (state == S_ERASE) ? old_y : cur_y;
   assign px = {1'b0, base_x} + {{(X_W-3){dx[3]}}, dx};
   assign py = {1'b0, base_y} + {{(Y_W-3){dy[3]}}, dy};
   assign on_screen = !px[X_W] && (px < X_LIM)
                   && !py[Y_W] && (py < Y_LIM);

   always_ff @(posedge clock) begin
      if (!resetn || !pix_on) begin
         vga.x      <= '0;
         vga.y      <= '0;
         vga.colour <= '0;
         vga.plot   <= 1'b0;
      end else begin
         vga.x      <= px[X_W-1:0];
         vga.y      <= py[Y_W-1:0];
         vga.colour <= (state == S_ERASE) ? BG_COLOUR : cur_col;
         vga.plot   <= on_screen;
      end
   end

endmodule

// File: tb/tb_sprite_plot_scheduler.sv
// Bench for sprite_plot_scheduler: per-cycle reference model of the
// frame pass plus directed passes with hand-computed expectations.
module tb_sprite_plot_scheduler;

   logic        clk = 1'b0;
   logic        resetn;
   logic        frame_tick;
   logic [1:0]  req;
   logic [1:0]  visible;
   logic [15:0] spr_x;
   logic [13:0] spr_y;
   logic [5:0]  spr_colour;
   logic [1:0]  ack;
   logic        busy;
   logic        overrun;

   sprite_plot_scheduler_if vga ();

   sprite_plot_scheduler dut (
      .clock      (clk),
      .resetn     (resetn),
      .frame_tick (frame_tick),
      .req        (req),
      .visible    (visible),
      .spr_x      (spr_x),
      .spr_y      (spr_y),
      .spr_colour (spr_colour),
      .ack        (ack),
      .busy       (busy),
      .overrun    (overrun),
      .vga        (vga)
   );

   always #5 clk = ~clk;

   localparam int DXT [13] = '{0, 0, -1, -2, -3, -4, -5, -3, -3, -4, -4, -5, -5};
   localparam int DYT [13] = '{0, 1, 0, 0, 0, 0, 0, 1, -1, 2, -2, 3, -3};

   typedef struct {
      bit pix;
      int x;
      int y;
      int c;
      int ack;
   } ent_t;

   ent_t fq[$];
   int   mpx [2];
   int   mpy [2];
   bit   mpv [2];
   bit   run;

   int checks;
   int errors;

   int m_busy, m_plots, m_a0, m_a1, m_ov, m_nack;
   int log_x [64];
   int log_y [64];
   int log_c [64];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_pix(input int ox, input int oy, input int col);
      for (int kk = 0; kk < 13; kk++) begin
         ent_t e;
         e.x   = ox + DXT[kk];
         e.y   = oy + DYT[kk];
         e.c   = col;
         e.ack = 0;
         e.pix = (e.x >= 0) && (e.x < 160) && (e.y >= 0) && (e.y < 120);
         fq.push_back(e);
      end
   endtask

   // One queue entry per non-idle scheduler cycle of the whole pass.
   task automatic build();
      ent_t e;
      for (int i = 0; i < 2; i++) begin
         if (req[i]) begin
            e.pix = 0; e.x = 0; e.y = 0; e.c = 0; e.ack = 0;
            fq.push_back(e);
            if (mpv[i]) push_pix(mpx[i], mpy[i], 0);
            if (visible[i])
               push_pix(int'(spr_x[8*i +: 8]), int'(spr_y[7*i +: 7]),
                        int'(spr_colour[3*i +: 3]));
            e.ack = 1 << i;
            fq.push_back(e);
            mpx[i] = int'(spr_x[8*i +: 8]);
            mpy[i] = int'(spr_y[7*i +: 7]);
            mpv[i] = visible[i];
         end
      end
   endtask

   task automatic compare_loop();
      ent_t cur;
      ent_t last;
      bit   idle;
      bit   exp_ov;
      last.pix = 0; last.x = 0; last.y = 0; last.c = 0; last.ack = 0;
      exp_ov = 0;
      forever begin
         @(negedge clk);
         if (!run) begin
            fq.delete();
            last.pix = 0;
            exp_ov = 0;
         end else begin
            idle = (fq.size() == 0);
            if (idle) begin
               cur.pix = 0; cur.x = 0; cur.y = 0; cur.c = 0; cur.ack = 0;
            end else begin
               cur = fq[0];
            end
            chk("busy", int'(busy), int'(!idle));
            chk("ack", int'(ack), cur.ack);
            chk("overrun", int'(overrun), int'(exp_ov));
            chk("plot", int'(vga.plot), int'(last.pix));
            if (last.pix) begin
               chk("x", int'(vga.x), last.x);
               chk("y", int'(vga.y), last.y);
               chk("colour", int'(vga.colour), last.c);
            end
            if (!resetn) begin
               fq.delete();
               last.pix = 0;
               exp_ov = 0;
               mpv[0] = 0;
               mpv[1] = 0;
            end else begin
               exp_ov = frame_tick && !idle;
               if (!idle) void'(fq.pop_front());
               last = cur;
               if (frame_tick && idle && (req != 2'b00)) build();
            end
         end
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic tick(input logic [1:0] r);
      req = r;
      frame_tick = 1'b1;
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
   endtask

   task automatic measure();
      int g;
      m_busy = 0; m_plots = 0; m_a0 = 0; m_a1 = 0; m_ov = 0; m_nack = 0;
      g = 0;
      do begin
         @(negedge clk);
         g++;
         if (busy) m_busy++;
         if (vga.plot) begin
            if (m_plots < 64) begin
               log_x[m_plots] = int'(vga.x);
               log_y[m_plots] = int'(vga.y);
               log_c[m_plots] = int'(vga.colour);
            end
            m_plots++;
         end
         if (ack[0]) begin m_a0 = m_busy; m_nack++; end
         if (ack[1]) begin m_a1 = m_busy; m_nack++; end
         if (overrun) m_ov++;
      end while (busy && g < 200);
      if (g >= 200) chk("pass_timeout", g, 0);
   endtask

   task automatic stimulus();
      resetn = 1'b0; frame_tick = 1'b0; req = '0; visible = '0;
      spr_x = '0; spr_y = '0; spr_colour = '0; run = 1'b0;
      step(2);
      run = 1'b1;
      step(1);
      resetn = 1'b1;
      step(2);

      // Fresh sprite 0: draw only.
      spr_x[7:0] = 8'd50; spr_y[6:0] = 7'd60; spr_colour[2:0] = 3'b111;
      visible = 2'b01;
      tick(2'b01);
      measure();
      chk("p1_busy", m_busy, 15);
      chk("p1_plots", m_plots, 13);
      chk("p1_ack0_at", m_a0, 15);
      chk("p1_first_x", log_x[0], 50);
      chk("p1_first_y", log_y[0], 60);
      chk("p1_last_x", log_x[12], 45);
      chk("p1_last_y", log_y[12], 57);
      chk("p1_colour", log_c[0], 7);

      // Move: erase old then draw new.
      step(1);
      spr_x[7:0] = 8'd51;
      tick(2'b01);
      measure();
      chk("p2_busy", m_busy, 28);
      chk("p2_plots", m_plots, 26);
      chk("p2_ack0_at", m_a0, 28);
      chk("p2_erase_x", log_x[0], 50);
      chk("p2_erase_c", log_c[0], 0);
      chk("p2_draw_x", log_x[13], 51);
      chk("p2_draw_c", log_c[13], 7);

      // Both sprites, sprite 1 near the corner; mid-pass tick and input change.
      step(1);
      spr_x[15:8] = 8'd2; spr_y[13:7] = 7'd118; spr_colour[5:3] = 3'b010;
      visible = 2'b11;
      tick(2'b11);
      fork
         measure();
         begin
            step(5);
            frame_tick = 1'b1;
            spr_x[7:0] = 8'd52;
            step(1);
            frame_tick = 1'b0;
         end
      join
      chk("p3_busy", m_busy, 43);
      chk("p3_ack0_at", m_a0, 28);
      chk("p3_ack1_at", m_a1, 43);
      chk("p3_plots", m_plots, 30);
      chk("p3_overrun", m_ov, 1);

      // Sprite 0 hidden: erase only at the latched 51.
      step(1);
      visible = 2'b10;
      tick(2'b01);
      measure();
      chk("p4_busy", m_busy, 15);
      chk("p4_plots", m_plots, 13);
      chk("p4_erase_x", log_x[0], 51);
      chk("p4_erase_c", log_c[0], 0);

      // Nothing left to erase or draw.
      step(1);
      tick(2'b01);
      measure();
      chk("p5_busy", m_busy, 2);
      chk("p5_plots", m_plots, 0);
      chk("p5_ack0_at", m_a0, 2);

      // Empty request: no pass.
      step(1);
      tick(2'b00);
      measure();
      chk("p6_busy", m_busy, 0);

      // Sprite 1 past the right edge.
      step(1);
      spr_x[15:8] = 8'd161; spr_y[13:7] = 7'd20;
      tick(2'b10);
      measure();
      chk("p7_busy", m_busy, 28);
      chk("p7_plots", m_plots, 14);
      chk("p7_ack1_at", m_a1, 28);

      // Reset in the middle of a draw.
      step(1);
      visible = 2'b11;
      tick(2'b01);
      fork
         measure();
         begin
            step(6);
            resetn = 1'b0;
            step(1);
            resetn = 1'b1;
         end
      join
      chk("p8_busy", m_busy, 7);
      chk("p8_plots", m_plots, 5);
      chk("p8_acks", m_nack, 0);

      // Reset cleared prev_valid, so this is draw only.
      step(1);
      tick(2'b01);
      measure();
      chk("p9_busy", m_busy, 15);
      chk("p9_plots", m_plots, 13);

      step(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      fork
         compare_loop();
         stimulus();
      join_any
   end

endmodule
